trap_csr: RTL and testbench
===========================

# trap_csr

Machine-mode trap CSR file for the Saratoga core. Holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval and the mcycle/minstret counters. Serves Zicsr reads and writes from the Execute Stage and commits trap entry and MRET state when the Control Unit inserts a trap. Drives the masked `interrupts`, `mepc` and `mtvec` values consumed by the trap unit.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (base and mode)
- MISA_VALUE, 32'h4000_0100, read-only misa contents (RV32I)

- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- csr_en  in  1  CSR instruction valid in Execute Stage
- csr_addr  in  12  CSR address
- csr_op  in  2  csr_op_t: CSR_RW=01, CSR_RS=10, CSR_RC=11 (00 = none)
- csr_we  in  1  instruction writes the CSR (0 for CSRRS/RC with rs1=x0/zimm=0)
- csr_wdata  in  32  rs1 or zero-extended zimm
- csr_rdata  out  32  current CSR value (pre-write)
- csr_illegal  out  1  unimplemented address, or write to read-only CSR
- trap_insert  in  1  Control Unit commits a trap or MRET this cycle
- trap_is_mret  in  1  committed trap is MRET
- trap_epc, trap_cause, trap_val  in  32 each  values written on trap entry
- irq_soft, irq_timer, irq_ext  in  1 each  level-sensitive interrupt lines
- instret  in  1  one instruction retired this cycle
- interrupts  out  32  mip & mie, all zero when mstatus.MIE=0
- mepc  out  32  mepc register
- mtvec  out  32  mtvec register

## Operation
- Address map: mstatus 0x300, misa 0x301 (RO), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (writes ignored, not illegal), mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mvendorid/marchid/mimpid/mhartid 0xF11–0xF14 (RO, read 0).
- csr_illegal = csr_en & (address unmapped | (csr_addr[11:10]==2'b11 & csr_we)). No state changes when illegal.
- New value: RW → wdata; RS → old|wdata; RC → old&~wdata. Written only when csr_en & csr_we & !csr_illegal & !trap_insert.
- WARL rules: mstatus writable bits MIE[3], MPIE[7] only; MPP[12:11] reads 2'b11. mie writable bits 3,7,11 only. mtvec[1] forced 0. mepc[1:0] forced 0.
- mip[3]/[7]/[11] register irq_soft/irq_timer/irq_ext every cycle.
- Trap entry (trap_insert & !trap_is_mret): MPIE←MIE, MIE←0, mepc←trap_epc (bits[1:0] cleared), mcause←trap_cause, mtval←trap_val.
- MRET (trap_insert & trap_is_mret): MIE←MPIE, MPIE←1; mepc/mcause/mtval unchanged.
- trap_insert has priority over a simultaneous CSR write; the write is dropped.
- mcycle increments every cycle; minstret increments when instret. 64-bit, wraps to 0. A write to a half replaces that half and suppresses the increment for the whole counter that cycle.

## Timing
- Reset: mstatus MIE=0, MPIE=0; mie, mip, mscratch, mepc, mcause, mtval, counters = 0; mtvec = MTVEC_RESET; interrupts = 0; csr_rdata = 0 while rst_n=0.
- csr_rdata and csr_illegal are combinational from the current registers; writes are visible the following cycle.
- irq line → interrupts: 1 cycle. mie/mstatus write → interrupts: next cycle.
- Trap/MRET updates take effect on the trap_insert edge. interrupts drops to 0 the cycle after trap entry.
- Low-to-high carry applies within the same cycle; reading mcycle returns the pre-increment value.

## Structure
- Package saratoga: CSR address constants, csr_op_t, mstatus bit indices (MSTATUS_MIE=3, MSTATUS_MPIE=7), MIP/MIE bit indices, MTVEC_ADDR_BIT_ALIGN.
- Sub-module csr_counter64: 64-bit counter with increment enable and per-half write ports, instanced for mcycle and minstret.

## Test plan
- Reset, then read 0x300/0x305/0xB00 → mstatus=0x0000_1800, mtvec=MTVEC_RESET, mcycle equal to cycles since reset release.
- Write mie=0x888, mstatus RS 0x8, raise irq_timer → interrupts=0x80 one cycle later; clear MIE → interrupts=0.
- trap_insert with epc=0x1002, cause=0x8000_0007, val=0, MIE=1 → mepc=0x1000, mcause=0x8000_0007, MIE=0, MPIE=1; MRET → MIE=1, MPIE=1.
- Same-cycle CSR write mscratch=0x55 and trap_insert → mscratch unchanged, trap state committed.
- Write mcycle=0xFFFF_FFFF, mcycleh=0 → two cycles later mcycleh=1, mcycle=0x0000_0001; CSRRW to 0xF14 → csr_illegal=1, no state change.
- Write mtvec=0x2003 → reads back 0x2001; read unmapped 0x7C0 → csr_illegal=1.

Source files
------------

// File: rtl/saratoga.sv
// saratoga: shared definitions for the Saratoga machine-mode CSR file.
//   - CSR address map constants
//   - csr_op_t encoding used by the Execute Stage
//   - mstatus / mie / mip bit indices and write masks
//   - csr_apply(): the RW/RS/RC read-modify-write rule
package saratoga;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_t;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    // mtvec bit that is hard-wired to zero (only modes 0/1 exist)
    localparam int MTVEC_ADDR_BIT_ALIGN = 1;

    localparam logic [31:0] MSTATUS_WMASK = (32'd1 << MSTATUS_MIE) | (32'd1 << MSTATUS_MPIE);
    // MPP is fixed at M-mode; always reads back 2'b11
    localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK = (32'd1 << MIP_MSIP) | (32'd1 << MIP_MTIP) | (32'd1 << MIP_MEIP);
    localparam logic [31:0] MTVEC_WMASK = ~(32'd1 << MTVEC_ADDR_BIT_ALIGN);
    localparam logic [31:0] MEPC_WMASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] csr_apply(input csr_op_t op, input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        case (op)
            CSR_RW:  return wdata;
            CSR_RS:  return old_val | wdata;
            CSR_RC:  return old_val & ~wdata;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit performance counter with per-half write ports.
//   clk, rst_n  : clock, synchronous active-low reset
//   inc         : add one this cycle (carry ripples into the high half)
//   wr_lo/wr_hi : replace the low/high half with wdata; any write
//                 suppresses the increment for the whole counter
//   wdata       : write data for either half
//   count       : current 64-bit value
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata;
            if (wr_hi) count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/trap_csr.sv
// trap_csr: machine-mode trap CSR file for the Saratoga core.
//   Zicsr access  : csr_en/csr_addr/csr_op/csr_we/csr_wdata in,
//                   csr_rdata (pre-write value) / csr_illegal out, both combinational
//   Trap commit   : trap_insert/trap_is_mret/trap_epc/trap_cause/trap_val
//   Interrupts    : irq_soft/irq_timer/irq_ext sampled into mip each cycle
//   Counters      : mcycle free-running, minstret on instret
//   To trap unit  : interrupts (mip & mie gated by mstatus.MIE), mepc, mtvec
module trap_csr
    import saratoga::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_en,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_insert,
    input  logic        trap_is_mret,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_val,
    input  logic        irq_soft,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        instret,
    output logic [31:0] interrupts,
    output logic [31:0] mepc,
    output logic [31:0] mtvec
);

    // index 0 = mcycle, 1 = minstret
    localparam int NUM_CNT = 2;

    logic [31:0] mstatus_q, mie_q, mip_q, mscratch_q, mcause_q, mtval_q;
    logic [31:0] rd_val, new_val;
    logic        mapped, wr_en;

    logic [NUM_CNT-1:0][63:0] cnt;
    logic [NUM_CNT-1:0]       cnt_inc, cnt_wr_lo, cnt_wr_hi;

    // ---------------- read mux / address decode ----------------
    always_comb begin
        mapped = 1'b1;
        rd_val = '0;
        case (csr_addr)
            CSR_MSTATUS:   rd_val = mstatus_q | MSTATUS_MPP_RO;
            CSR_MISA:      rd_val = MISA_VALUE;
            CSR_MIE:       rd_val = mie_q;
            CSR_MTVEC:     rd_val = mtvec;
            CSR_MSCRATCH:  rd_val = mscratch_q;
            CSR_MEPC:      rd_val = mepc;
            CSR_MCAUSE:    rd_val = mcause_q;
            CSR_MTVAL:     rd_val = mtval_q;
            CSR_MIP:       rd_val = mip_q;
            CSR_MCYCLE:    rd_val = cnt[0][31:0];
            CSR_MINSTRET:  rd_val = cnt[1][31:0];
            CSR_MCYCLEH:   rd_val = cnt[0][63:32];
            CSR_MINSTRETH: rd_val = cnt[1][63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: rd_val = '0;
            default:       mapped = 1'b0;
        endcase
    end

    assign csr_rdata   = rst_n ? rd_val : '0;
    // address[11:10]==11 marks the read-only CSR space
    assign csr_illegal = csr_en & (~mapped | ((csr_addr[11:10] == 2'b11) & csr_we));
    // a committing trap/MRET wins over the instruction's CSR write
    assign wr_en       = csr_en & csr_we & ~csr_illegal & ~trap_insert
                       & (csr_op != CSR_NONE);
    assign new_val     = csr_apply(csr_op_t'(csr_op), rd_val, csr_wdata);

    assign interrupts  = mstatus_q[MSTATUS_MIE] ? (mip_q & mie_q) : '0;

    // ---------------- architectural registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec      <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc       <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mip_q <= ({31'b0, irq_soft}  << MIP_MSIP)
                   | ({31'b0, irq_timer} << MIP_MTIP)
                   | ({31'b0, irq_ext}   << MIP_MEIP);

            if (trap_insert) begin
                if (trap_is_mret) begin
                    mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
                    mstatus_q[MSTATUS_MPIE] <= 1'b1;
                end else begin
                    mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
                    mstatus_q[MSTATUS_MIE]  <= 1'b0;
                    mepc                    <= trap_epc & MEPC_WMASK;
                    mcause_q                <= trap_cause;
                    mtval_q                 <= trap_val;
                end
            end else if (wr_en) begin
                case (csr_addr)
                    CSR_MSTATUS:  mstatus_q  <= new_val & MSTATUS_WMASK;
                    CSR_MIE:      mie_q      <= new_val & MIE_WMASK;
                    CSR_MTVEC:    mtvec      <= new_val & MTVEC_WMASK;
                    CSR_MSCRATCH: mscratch_q <= new_val;
                    CSR_MEPC:     mepc       <= new_val & MEPC_WMASK;
                    CSR_MCAUSE:   mcause_q   <= new_val;
                    CSR_MTVAL:    mtval_q    <= new_val;
                    default:      ;  // mip ignored; counters handled below
                endcase
            end
        end
    end

    // ---------------- 64-bit counters ----------------
    assign cnt_inc      = {instret, 1'b1};
    assign cnt_wr_lo[0] = wr_en & (csr_addr == CSR_MCYCLE);
    assign cnt_wr_hi[0] = wr_en & (csr_addr == CSR_MCYCLEH);
    assign cnt_wr_lo[1] = wr_en & (csr_addr == CSR_MINSTRET);
    assign cnt_wr_hi[1] = wr_en & (csr_addr == CSR_MINSTRETH);

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        csr_counter64 u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (cnt_inc[i]),
            .wr_lo (cnt_wr_lo[i]),
            .wr_hi (cnt_wr_hi[i]),
            .wdata (new_val),
            .count (cnt[i])
        );
    end

endmodule

// File: tb/tb_trap_csr.sv
// tb_trap_csr: directed self-checking bench for trap_csr.
// Expected values are pushed to a scoreboard when a step is driven and
// popped when the corresponding DUT output is sampled (1 time unit after
// inputs settle, well away from the rising edge).
module tb_trap_csr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_en = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_insert = 1'b0;
    logic        trap_is_mret = 1'b0;
    logic [31:0] trap_epc = '0, trap_cause = '0, trap_val = '0;
    logic        irq_soft = 1'b0, irq_timer = 1'b0, irq_ext = 1'b0;
    logic        instret = 1'b0;
    logic [31:0] interrupts, mepc, mtvec;

    localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

    trap_csr #(.MTVEC_RESET(32'h0000_0000), .MISA_VALUE(32'h4000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_en(csr_en), .csr_addr(csr_addr), .csr_op(csr_op), .csr_we(csr_we),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_insert(trap_insert), .trap_is_mret(trap_is_mret),
        .trap_epc(trap_epc), .trap_cause(trap_cause), .trap_val(trap_val),
        .irq_soft(irq_soft), .irq_timer(irq_timer), .irq_ext(irq_ext),
        .instret(instret), .interrupts(interrupts), .mepc(mepc), .mtvec(mtvec)
    );

    always #5 clk = ~clk;

    // cycles since reset release, for the free-running mcycle check
    int unsigned cyc = 0;
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic cmp(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got %h with no expectation queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: got %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_en = 1'b0; csr_we = 1'b0; csr_op = 2'b00; csr_wdata = '0;
        trap_insert = 1'b0; trap_is_mret = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_en = 1'b1; csr_addr = a; csr_op = op; csr_we = 1'b1; csr_wdata = d;
        step();
        idle();
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_en = 1'b1; csr_addr = a; csr_op = RS; csr_we = 1'b0; csr_wdata = '0;
        push(tag, exp);
        #1 cmp(csr_rdata);
        step();
        idle();
    endtask

    initial begin
        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        csr_en = 1'b1; csr_addr = 12'h300; csr_op = RS;
        push("rst_rdata", 32'h0);      #1 cmp(csr_rdata);
        push("rst_interrupts", 32'h0); cmp(interrupts);
        idle();
        step();
        rst_n = 1'b1;
        repeat (4) step();

        rd("mstatus_rst", 12'h300, 32'h0000_1800);
        rd("mtvec_rst",   12'h305, 32'h0000_0000);
        rd("mcycle_rst",  12'hB00, cyc);
        rd("misa",        12'h301, 32'h4000_0100);
        rd("mhartid",     12'hF14, 32'h0);

        // ---- interrupt masking ----
        wr(12'h304, RW, 32'hFFFF_FFFF);
        rd("mie_warl", 12'h304, 32'h0000_0888);
        wr(12'h300, RS, 32'h8);
        rd("mstatus_mie", 12'h300, 32'h0000_1808);
        irq_timer = 1'b1;
        push("irq_same_cycle", 32'h0); #1 cmp(interrupts);
        step();
        push("irq_1cyc", 32'h80); cmp(interrupts);
        rd("mip", 12'h344, 32'h80);
        wr(12'h300, RC, 32'h8);
        push("irq_mie_off", 32'h0); cmp(interrupts);
        wr(12'h300, RS, 32'h8);
        push("irq_mie_on", 32'h80); cmp(interrupts);

        // ---- trap entry / MRET ----
        trap_insert = 1'b1; trap_epc = 32'h1002; trap_cause = 32'h8000_0007; trap_val = 32'h0;
        step();
        idle();
        push("irq_after_trap", 32'h0); cmp(interrupts);
        push("mepc_trap", 32'h1000);  cmp(mepc);
        rd("mcause_trap",  12'h342, 32'h8000_0007);
        rd("mstatus_trap", 12'h300, 32'h0000_1880);
        trap_insert = 1'b1; trap_is_mret = 1'b1;
        step();
        idle();
        rd("mstatus_mret", 12'h300, 32'h0000_1888);
        push("mepc_mret", 32'h1000); cmp(mepc);

        // ---- trap beats simultaneous CSR write ----
        csr_en = 1'b1; csr_we = 1'b1; csr_op = RW; csr_addr = 12'h340; csr_wdata = 32'h55;
        trap_insert = 1'b1; trap_epc = 32'h2000; trap_cause = 32'hB; trap_val = 32'h1234;
        step();
        idle();
        rd("mscratch_dropped", 12'h340, 32'h0);
        rd("mepc_trap2",       12'h341, 32'h2000);
        rd("mtval_trap2",      12'h343, 32'h1234);
        rd("mstatus_trap2",    12'h300, 32'h0000_1880);
        wr(12'h340, RW, 32'hAA);
        rd("mscratch_wr", 12'h340, 32'hAA);
        irq_timer = 1'b0;

        // ---- mcycle carry, written halves suppress increment ----
        wr(12'hB00, RW, 32'hFFFF_FFFF);
        wr(12'hB80, RW, 32'h0);
        step();
        step();
        csr_en = 1'b1; csr_op = RS; csr_we = 1'b0;
        csr_addr = 12'hB80; push("mcycleh_carry", 32'h1); #1 cmp(csr_rdata);
        csr_addr = 12'hB00; push("mcycle_carry",  32'h1); #1 cmp(csr_rdata);
        idle();
        step();

        // ---- minstret ----
        instret = 1'b1;
        repeat (3) step();
        instret = 1'b0;
        rd("minstret",  12'hB02, 32'h3);
        rd("minstreth", 12'hB82, 32'h0);

        // ---- illegal accesses ----
        csr_en = 1'b1; csr_we = 1'b1; csr_op = RW; csr_addr = 12'hF14; csr_wdata = 32'hDEAD;
        push("illegal_ro_write", 32'h1); #1 cmp({31'b0, csr_illegal});
        step();
        idle();
        rd("mhartid_after", 12'hF14, 32'h0);
        rd("mscratch_after", 12'h340, 32'hAA);
        csr_en = 1'b1; csr_we = 1'b0; csr_op = RS; csr_addr = 12'hF11;
        push("ro_read_legal", 32'h0); #1 cmp({31'b0, csr_illegal});
        csr_addr = 12'h7C0;
        push("unmapped", 32'h1); #1 cmp({31'b0, csr_illegal});
        idle();
        step();

        // ---- WARL on mtvec / mepc ----
        csr_en = 1'b1; csr_we = 1'b1; csr_op = RW; csr_addr = 12'h305; csr_wdata = 32'h2003;
        push("mtvec_prewrite", 32'h0); #1 cmp(csr_rdata);
        step();
        idle();
        rd("mtvec_warl", 12'h305, 32'h2001);
        push("mtvec_port", 32'h2001); cmp(mtvec);
        wr(12'h341, RW, 32'h1237);
        rd("mepc_warl", 12'h341, 32'h1234);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
